sigmoid_arbiter: RTL and testbench

- Shares one sigmoid activation unit among N requesters, typically the neurons of a layer.
- Each requester runs a full transaction through the unit:
  - forward: argument in, result out;
  - training only: error in, feedback out.
- The grant is held for the whole transaction, because the unit keeps per-argument gradient state between its result and error phases.
- Fair round-robin scheduling; registered grant; combinational handshake steering to the owner.

---
 rtl/sigmoid_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sigmoid_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter sharing one sigmoid activation unit among N requesters.
// The grant is held across the full forward (and optional training) transaction.
module sigmoid_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              train,
  input  logic [N-1:0]      req_arg_stb,
  input  logic [16*N-1:0]   req_arg_dat,
  output logic [N-1:0]      req_arg_rdy,
  output logic [N-1:0]      req_res_stb,
  output logic [7:0]        req_res_dat,
  input  logic [N-1:0]      req_res_rdy,
  input  logic [N-1:0]      req_err_stb,
  input  logic [16*N-1:0]   req_err_dat,
  output logic [N-1:0]      req_err_rdy,
  output logic [N-1:0]      req_fbk_stb,
  output logic [15:0]       req_fbk_dat,
  input  logic [N-1:0]      req_fbk_rdy,
  output logic [N-1:0]      gnt,
  output logic              busy,
  output logic              act_en,
  output logic              act_arg_stb,
  output logic [15:0]       act_arg_dat,
  input  logic              act_arg_rdy,
  input  logic              act_res_stb,
  input  logic [7:0]        act_res_dat,
  output logic              act_res_rdy,
  output logic              act_err_stb,
  output logic [15:0]       act_err_dat,
  input  logic              act_err_rdy,
  input  logic              act_fbk_stb,
  input  logic [15:0]       act_fbk_dat,
  output logic              act_fbk_rdy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARG  = 3'd1,
    RES  = 3'd2,
    ERR  = 3'd3,
    FBK  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       gnt_q, gnt_d;
  logic [PTR_W-1:0]   idx_q, idx_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               mode_q, mode_d;

  logic [PTR_W-1:0]   sel_s;
  logic [PTR_W-1:0]   cand_s;
  logic               found_s;
  logic [PTR_W-1:0]   ptr_wrap_s;
  logic [15:0]        arg_sel_s;
  logic [15:0]        err_sel_s;

  // First requesting index at or after ptr, wrapping modulo N.
  always_comb begin
    sel_s   = ptr_q;
    cand_s  = ptr_q;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s = PTR_W'((int'(ptr_q) + k) % N);
      if (!found_s && req_arg_stb[cand_s]) begin
        found_s = 1'b1;
        sel_s   = cand_s;
      end else begin
        sel_s   = sel_s;
      end
    end
  end

  always_comb begin
    arg_sel_s = 16'h0000;
    err_sel_s = 16'h0000;
    for (int i = 0; i < N; i++) begin
      if (idx_q == PTR_W'(i)) begin
        arg_sel_s = req_arg_dat[16*i +: 16];
        err_sel_s = req_err_dat[16*i +: 16];
      end else begin
        arg_sel_s = arg_sel_s;
        err_sel_s = err_sel_s;
      end
    end
  end

  assign ptr_wrap_s = (idx_q == PTR_W'(N - 1)) ? {PTR_W{1'b0}} : idx_q + PTR_W'(1);

  // Next state and owner-steered handshakes; everything outside the live channel stays 0.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    mode_d      = mode_q;
    req_arg_rdy = {N{1'b0}};
    req_res_stb = {N{1'b0}};
    req_err_rdy = {N{1'b0}};
    req_fbk_stb = {N{1'b0}};
    act_arg_stb = 1'b0;
    act_arg_dat = 16'h0000;
    act_res_rdy = 1'b0;
    act_err_stb = 1'b0;
    act_err_dat = 16'h0000;
    act_fbk_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_arg_stb) begin
          state_d = ARG;
          gnt_d   = N'(1) << sel_s;
          idx_d   = sel_s;
          mode_d  = train;
        end else begin
          state_d = IDLE;
        end
      end
      ARG: begin
        act_arg_stb = |(req_arg_stb & gnt_q);
        act_arg_dat = arg_sel_s;
        req_arg_rdy = gnt_q & {N{act_arg_rdy}};
        if (act_arg_stb && act_arg_rdy) begin
          state_d = RES;
        end else begin
          state_d = ARG;
        end
      end
      RES: begin
        req_res_stb = gnt_q & {N{act_res_stb}};
        act_res_rdy = |(req_res_rdy & gnt_q);
        if (act_res_stb && act_res_rdy && mode_q) begin
          state_d = ERR;
        end else if (act_res_stb && act_res_rdy) begin
          state_d = IDLE;
          gnt_d   = {N{1'b0}};
          ptr_d   = ptr_wrap_s;
        end else begin
          state_d = RES;
        end
      end
      ERR: begin
        act_err_stb = |(req_err_stb & gnt_q);
        act_err_dat = err_sel_s;
        req_err_rdy = gnt_q & {N{act_err_rdy}};
        if (act_err_stb && act_err_rdy) begin
          state_d = FBK;
        end else begin
          state_d = ERR;
        end
      end
      FBK: begin
        req_fbk_stb = gnt_q & {N{act_fbk_stb}};
        act_fbk_rdy = |(req_fbk_rdy & gnt_q);
        if (act_fbk_stb && act_fbk_rdy) begin
          state_d = IDLE;
          gnt_d   = {N{1'b0}};
          ptr_d   = ptr_wrap_s;
        end else begin
          state_d = FBK;
        end
      end
      default: begin
        state_d = state_e'(3'bxxx);
        gnt_d   = {N{1'b0}};
      end
    endcase
  end

  // State, grant, pointer and mode registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= {N{1'b0}};
      idx_q   <= {PTR_W{1'b0}};
      ptr_q   <= {PTR_W{1'b0}};
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
    end
  end

  assign gnt         = gnt_q;
  assign busy        = (state_q != IDLE);
  assign act_en      = mode_q;
  assign req_res_dat = act_res_dat;
  assign req_fbk_dat = act_fbk_dat;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Self-checking bench for sigmoid_arbiter: the bench plays both the requesters and
// the activation unit and predicts grants with a round-robin reference model.
module tb_sigmoid_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            train;
  logic [N-1:0]    req_arg_stb;
  logic [16*N-1:0] req_arg_dat;
  logic [N-1:0]    req_arg_rdy;
  logic [N-1:0]    req_res_stb;
  logic [7:0]      req_res_dat;
  logic [N-1:0]    req_res_rdy;
  logic [N-1:0]    req_err_stb;
  logic [16*N-1:0] req_err_dat;
  logic [N-1:0]    req_err_rdy;
  logic [N-1:0]    req_fbk_stb;
  logic [15:0]     req_fbk_dat;
  logic [N-1:0]    req_fbk_rdy;
  logic [N-1:0]    gnt;
  logic            busy, act_en;
  logic            act_arg_stb, act_arg_rdy;
  logic [15:0]     act_arg_dat;
  logic            act_res_stb, act_res_rdy;
  logic [7:0]      act_res_dat;
  logic            act_err_stb, act_err_rdy;
  logic [15:0]     act_err_dat;
  logic            act_fbk_stb, act_fbk_rdy;
  logic [15:0]     act_fbk_dat;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  sigmoid_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst), .train(train),
    .req_arg_stb(req_arg_stb), .req_arg_dat(req_arg_dat), .req_arg_rdy(req_arg_rdy),
    .req_res_stb(req_res_stb), .req_res_dat(req_res_dat), .req_res_rdy(req_res_rdy),
    .req_err_stb(req_err_stb), .req_err_dat(req_err_dat), .req_err_rdy(req_err_rdy),
    .req_fbk_stb(req_fbk_stb), .req_fbk_dat(req_fbk_dat), .req_fbk_rdy(req_fbk_rdy),
    .gnt(gnt), .busy(busy), .act_en(act_en),
    .act_arg_stb(act_arg_stb), .act_arg_dat(act_arg_dat), .act_arg_rdy(act_arg_rdy),
    .act_res_stb(act_res_stb), .act_res_dat(act_res_dat), .act_res_rdy(act_res_rdy),
    .act_err_stb(act_err_stb), .act_err_dat(act_err_dat), .act_err_rdy(act_err_rdy),
    .act_fbk_stb(act_fbk_stb), .act_fbk_dat(act_fbk_dat), .act_fbk_rdy(act_fbk_rdy)
  );

  // Round-robin rule: first requester at or after ptr, wrapping.
  function automatic int model_pick(int ptr, logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    train = 1'b0; req_arg_stb = '0; req_res_rdy = '0; req_err_stb = '0; req_fbk_rdy = '0;
    act_arg_rdy = 1'b0; act_res_stb = 1'b0; act_err_rdy = 1'b0; act_fbk_stb = 1'b0;
    act_res_dat = 8'h00; act_fbk_dat = 16'h0000;
  endtask

  // One full transaction; the model chooses the owner, the bench plays the unit.
  task automatic run_txn(input bit tr, input logic [15:0] err_v, input int res_stall, output int got);
    int exp, n_stall;
    logic [N-1:0] own;
    logic [7:0]   r;
    logic [15:0]  f, a;
    exp = model_pick(m_ptr, req_arg_stb);
    own = N'(1) << exp;
    a   = req_arg_dat[16*exp +: 16];
    got = -1;
    train = tr;
    @(negedge clk);
    checks++; if ({busy, gnt, req_arg_rdy, act_arg_stb} !== '0) begin errors++; $display("FAIL arb_cycle: busy=%b gnt=%b arg_rdy=%b arg_stb=%b required all 0", busy, gnt, req_arg_rdy, act_arg_stb); end
    checks++; if (dut.ptr_q !== 2'(m_ptr)) begin errors++; $display("FAIL ptr: got %0d required %0d", dut.ptr_q, m_ptr); end
    tick();
    train = ~tr;
    n_stall = $urandom_range(0, 2);
    for (int s = 0; s <= n_stall; s++) begin
      act_arg_rdy = (s == n_stall);
      @(negedge clk);
      if (s == 0) begin
        for (int i = 0; i < N; i++) if (gnt[i]) got = i;
      end
      checks++; if (gnt !== own) begin errors++; $display("FAIL arg_gnt: got %b required %b", gnt, own); end
      checks++; if ({busy, act_en, act_arg_stb} !== {1'b1, tr, 1'b1}) begin errors++; $display("FAIL arg_ctl: busy/en/stb got %b required %b", {busy, act_en, act_arg_stb}, {1'b1, tr, 1'b1}); end
      checks++; if (act_arg_dat !== a) begin errors++; $display("FAIL arg_dat: got %h required %h", act_arg_dat, a); end
      checks++; if (req_arg_rdy !== (act_arg_rdy ? own : '0)) begin errors++; $display("FAIL arg_rdy: got %b required %b", req_arg_rdy, act_arg_rdy ? own : '0); end
      tick();
    end
    req_arg_stb[exp] = 1'b0;
    req_arg_dat[16*exp +: 16] = 16'($urandom);
    act_arg_rdy = 1'b0;
    r = 8'($urandom);
    act_res_stb = 1'b1; act_res_dat = r; req_err_stb = '1; act_err_rdy = 1'b1;
    for (int s = 0; s <= res_stall; s++) begin
      req_res_rdy = N'($urandom);
      req_res_rdy[exp] = (s == res_stall);
      @(negedge clk);
      checks++; if ({gnt, req_res_stb, req_res_dat} !== {own, own, r}) begin errors++; $display("FAIL res_steer: gnt=%b res_stb=%b dat=%h required %b %b %h", gnt, req_res_stb, req_res_dat, own, own, r); end
      checks++; if (act_res_rdy !== (s == res_stall)) begin errors++; $display("FAIL res_rdy: got %b required %b", act_res_rdy, s == res_stall); end
      checks++; if ({act_err_stb, req_err_rdy, act_arg_stb, req_arg_rdy} !== '0) begin errors++; $display("FAIL res_gating: err_stb=%b err_rdy=%b arg_stb=%b arg_rdy=%b required all 0", act_err_stb, req_err_rdy, act_arg_stb, req_arg_rdy); end
      tick();
    end
    act_res_stb = 1'b0; req_res_rdy = '0; req_err_stb = '0; act_err_rdy = 1'b0;
    if (tr) begin
      req_err_dat = {$urandom, $urandom};
      req_err_dat[16*exp +: 16] = err_v;
      req_err_stb = N'($urandom); req_err_stb[exp] = 1'b1; act_err_rdy = 1'b1;
      @(negedge clk);
      checks++; if ({act_err_stb, act_err_dat, act_en} !== {1'b1, err_v, 1'b1}) begin errors++; $display("FAIL err_fwd: stb=%b dat=%h en=%b required 1 %h 1", act_err_stb, act_err_dat, act_en, err_v); end
      checks++; if ({gnt, req_err_rdy, req_res_stb} !== {own, own, {N{1'b0}}}) begin errors++; $display("FAIL err_steer: gnt=%b err_rdy=%b res_stb=%b required %b %b 0", gnt, req_err_rdy, req_res_stb, own, own); end
      tick();
      req_err_stb = '0; act_err_rdy = 1'b0;
      f = 16'($urandom);
      act_fbk_stb = 1'b1; act_fbk_dat = f; req_fbk_rdy = '1;
      @(negedge clk);
      checks++; if ({req_fbk_stb, req_fbk_dat, act_fbk_rdy, act_err_stb} !== {own, f, 1'b1, 1'b0}) begin errors++; $display("FAIL fbk_steer: stb=%b dat=%h rdy=%b err_stb=%b required %b %h 1 0", req_fbk_stb, req_fbk_dat, act_fbk_rdy, act_err_stb, own, f); end
      tick();
      act_fbk_stb = 1'b0; req_fbk_rdy = '0;
    end
    m_ptr = (exp + 1) % N;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0; train = 1'b1;
    req_arg_stb = N'($urandom); req_err_stb = '1; act_res_stb = 1'b1; act_fbk_stb = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if ({gnt, busy, act_en} !== '0) begin errors++; $display("FAIL reset_state: gnt=%b busy=%b en=%b required 0", gnt, busy, act_en); end
    checks++; if ({req_arg_rdy, req_res_stb, req_err_rdy, req_fbk_stb, act_arg_stb, act_res_rdy, act_err_stb, act_fbk_rdy} !== '0) begin errors++; $display("FAIL reset_hs: some strobe/rdy high, required all 0"); end
    checks++; if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL reset_ptr: got %0d required 0", dut.ptr_q); end
    clear_inputs();
    tick();
    rst = 1'b1;
    m_ptr = 0;
    tick();
  endtask

  task automatic test_single();
    int got;
    req_arg_dat[16*2 +: 16] = 16'h0100;
    req_arg_stb = 4'b0100;
    run_txn(1'b0, 16'h0000, 0, got);
    checks++; if (got !== 2) begin errors++; $display("FAIL single_owner: got %0d required 2", got); end
    @(negedge clk);
    checks++; if ({busy, gnt} !== '0 || dut.ptr_q !== 2'd3) begin errors++; $display("FAIL single_end: busy=%b gnt=%b ptr=%0d required 0 0 3", busy, gnt, dut.ptr_q); end
    tick();
  endtask

  task automatic test_fairness();
    int got;
    int order [5] = '{0, 1, 2, 3, 0};
    test_reset();
    req_arg_dat = {$urandom, $urandom};
    for (int t = 0; t < 5; t++) begin
      req_arg_stb = '1;
      run_txn(1'b0, 16'h0000, 0, got);
      checks++; if (got !== order[t]) begin errors++; $display("FAIL fair_order[%0d]: got %0d required %0d", t, got, order[t]); end
    end
    req_arg_stb = '0;
    tick();
  endtask

  task automatic test_training();
    int got;
    req_arg_dat[16*1 +: 16] = 16'h0000;
    req_arg_stb = 4'b0010;
    run_txn(1'b1, 16'h0400, 0, got);
    checks++; if (got !== 1) begin errors++; $display("FAIL train_owner: got %0d required 1", got); end
    tick();
  endtask

  task automatic test_backpressure();
    int got;
    req_arg_stb = 4'b1001;
    run_txn(1'b0, 16'h0000, 5, got);
    checks++; if (got !== 3) begin errors++; $display("FAIL bp_owner: got %0d required 3", got); end
    run_txn(1'b0, 16'h0000, 0, got);
    checks++; if (got !== 0) begin errors++; $display("FAIL bp_next: got %0d required 0", got); end
    tick();
  endtask

  task automatic test_reset_mid_err();
    int got;
    req_arg_stb = 4'b0100; train = 1'b1;
    tick();
    act_arg_rdy = 1'b1;
    tick();
    req_arg_stb = '0; act_arg_rdy = 1'b0; act_res_stb = 1'b1; req_res_rdy = '1;
    tick();
    act_res_stb = 1'b0; req_res_rdy = '0; req_err_stb = 4'b0100;
    @(negedge clk);
    checks++; if ({act_err_stb, gnt} !== {1'b1, 4'b0100}) begin errors++; $display("FAIL pre_reset_err: stb=%b gnt=%b required 1 0100", act_err_stb, gnt); end
    rst = 1'b0;
    tick();
    rst = 1'b1; act_fbk_stb = 1'b1; req_fbk_rdy = '1;
    @(negedge clk);
    checks++; if ({gnt, busy, act_en} !== '0 || dut.ptr_q !== 2'd0) begin errors++; $display("FAIL midreset_state: gnt=%b busy=%b en=%b ptr=%0d required 0", gnt, busy, act_en, dut.ptr_q); end
    checks++; if ({req_arg_rdy, req_res_stb, req_err_rdy, req_fbk_stb, act_arg_stb, act_res_rdy, act_err_stb, act_fbk_rdy} !== '0) begin errors++; $display("FAIL midreset_hs: some strobe/rdy high, required all 0"); end
    clear_inputs();
    m_ptr = 0;
    tick();
    req_arg_stb = 4'b0001;
    run_txn(1'b0, 16'h0000, 0, got);
    checks++; if (got !== 0) begin errors++; $display("FAIL post_reset_owner: got %0d required 0", got); end
    tick();
  endtask

  task automatic test_random();
    int got;
    logic [N-1:0] nw;
    for (int t = 0; t < 20; t++) begin
      nw = N'($urandom);
      if ((nw | req_arg_stb) == '0) nw[$urandom_range(0, N-1)] = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (nw[i] && !req_arg_stb[i]) req_arg_dat[16*i +: 16] = 16'($urandom);
      end
      req_arg_stb = req_arg_stb | nw;
      run_txn(1'($urandom), 16'($urandom), $urandom_range(0, 3), got);
    end
    req_arg_stb = '0;
    tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    req_arg_dat = '0; req_err_dat = '0;
    test_reset();
    test_single();
    test_training();
    test_backpressure();
    test_reset_mid_err();
    test_fairness();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
